gsim_mem_arbiter: RTL
=====================

Name: gsim_mem_arbiter

Overview:
- Shares the single matrix-memory read port between two solver engines (requester 0 and requester 1).
- Grants the memory round-robin and records which requester owns each outstanding read in an in-order tag FIFO.
- Routes each returned 256-bit row to its owner with one registered cycle of latency.
- Sits between the solver engines and the matrix memory; neither engine changes its memory protocol.

Parameters:
- ADDR_W, 10, memory address width.
- DATA_W, 256, memory row width (16 x 16-bit coefficients).
- MAX_OUT, 4, maximum outstanding reads; tag FIFO depth, power of two, at least 2.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_req0_rreq  input  1  requester 0 read request.
- i_req0_addr  input  ADDR_W  requester 0 address.
- o_req0_rrdy  output  1  requester 0 request accepted this cycle.
- o_req0_dout  output  DATA_W  requester 0 read data.
- o_req0_dout_vld  output  1  requester 0 data valid.
- i_req1_rreq  input  1  requester 1 read request.
- i_req1_addr  input  ADDR_W  requester 1 address.
- o_req1_rrdy  output  1  requester 1 request accepted this cycle.
- o_req1_dout  output  DATA_W  requester 1 read data.
- o_req1_dout_vld  output  1  requester 1 data valid.
- o_mem_rreq  output  1  memory read request.
- o_mem_addr  output  ADDR_W  memory address.
- i_mem_rrdy  input  1  memory accepts request.
- i_mem_dout  input  DATA_W  memory read data.
- i_mem_dout_vld  input  1  memory data valid, returned in request order.
- o_err  output  1  sticky error: response arrived with no outstanding tag.

Behaviour:
- Reset (async, i_reset_n=0):
  - FIFO empty, count=0.
  - rr pointer = 1, so requester 0 wins the first tie.
  - All registered outputs 0: o_reqK_dout_vld, o_reqK_dout, o_err.
- Grant (combinational on current inputs and registered state):
  - Only one requester active: it wins.
  - Both active: the requester other than rr pointer wins.
- Request path (combinational):
  - o_mem_rreq = (i_req0_rreq | i_req1_rreq) & (count != MAX_OUT).
  - o_mem_addr = winner's address; 0 when no request is active.
  - o_reqK_rrdy = i_mem_rrdy & o_mem_rreq & winner==K.
- Accepted transfer = o_mem_rreq & i_mem_rrdy. On an accepted transfer:
  - Push winner id into the tag FIFO.
  - rr pointer <= winner.
  - With no accepted transfer, rr pointer holds.
- Full gating uses the registered count only. When count==MAX_OUT, o_mem_rreq=0 even if a pop occurs that same cycle.
- Response path, registered with 1-cycle latency:
  - On i_mem_dout_vld with FIFO non-empty: pop the head.
  - Next cycle, o_reqH_dout_vld=1 and o_reqH_dout=i_mem_dout, where H is the popped head. The other requester's vld=0.
  - o_reqK_dout holds its last value when not valid.
- Simultaneous push and pop: count unchanged, both pointers advance. Wrap-around is modulo MAX_OUT.
- Pop on empty FIFO (i_mem_dout_vld with count==0):
  - No pop, no dout_vld to either requester.
  - o_err <= 1; sticky until reset.
  - A push in the same cycle still succeeds, and count becomes 1.
- Reset mid-operation: all tags are discarded. Memory responses already in flight after reset hit the empty-FIFO rule and set o_err; the system resets memory together with the arbiter.
- No requester may withdraw i_reqK_rreq or change i_reqK_addr while waiting for rrdy. Violations are not detected, and the grant is re-evaluated every cycle.
- Throughput: one accepted request per cycle and one routed response per cycle, sustained.
- Latency:
  - Request: 0 cycles, combinational to memory.
  - Response: 1 cycle from i_mem_dout_vld to o_reqK_dout_vld.

Test Plan:
- Single requester: req0 reads addrs 0..16 back-to-back, memory rrdy=1, fixed 2-cycle response latency.
  -> 17 accepts on consecutive cycles; req0 gets 17 rows in order, each 1 cycle after mem vld; req1 vld never asserted.
- Contention: both rreq=1 from reset, req0 addr 0x011, req1 addr 0x022, rrdy=1.
  -> o_mem_addr sequence 0x011, 0x022, 0x011, 0x022…; responses alternate req0, req1.
- Full: rrdy=1, memory withholds vld for 10 cycles, MAX_OUT=4.
  -> exactly 4 accepts, then o_mem_rreq=0.
  -> On the first vld, the head is routed; o_mem_rreq reasserts the following cycle, not the same cycle.
- Simultaneous push/pop at count=MAX_OUT-1 with wrap-around across 3 FIFO cycles (≥12 transfers).
  -> Owner order preserved, count never exceeds MAX_OUT, no o_err.
- Spurious response: i_mem_dout_vld=1 with count=0.
  -> No dout_vld on either requester; o_err=1 next cycle and stays 1 until i_reset_n=0.
- Mid-operation reset: i_reset_n low for 1 cycle with 3 outstanding reads.
  -> All outputs 0 immediately; rr pointer=1; count=0; the next contention cycle grants req0.

Source files
------------

// File: rtl/gsim_mem_arbiter.sv
// Round-robin arbiter sharing one matrix-memory read port between two solver engines.
// An in-order tag FIFO remembers the owner of each outstanding read so rows return to the right engine.
module gsim_mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 256,
  parameter int MAX_OUT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req0_rreq,
  input  logic [ADDR_W-1:0] i_req0_addr,
  output logic              o_req0_rrdy,
  output logic [DATA_W-1:0] o_req0_dout,
  output logic              o_req0_dout_vld,
  input  logic              i_req1_rreq,
  input  logic [ADDR_W-1:0] i_req1_addr,
  output logic              o_req1_rrdy,
  output logic [DATA_W-1:0] o_req1_dout,
  output logic              o_req1_dout_vld,
  output logic              o_mem_rreq,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rrdy,
  input  logic [DATA_W-1:0] i_mem_dout,
  input  logic              i_mem_dout_vld,
  output logic              o_err
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUT);

  logic               rrPtr_q, rrPtr_d;
  logic [MAX_OUT-1:0] tagMem_q;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               req0Vld_q, req1Vld_q;
  logic [DATA_W-1:0]  req0Dout_q, req1Dout_q;

  logic anyReq, winner, memRreq, push, pop, fifoEmpty, headTag;

  // When both engines ask, the one that did not win last time gets the port.
  assign anyReq    = i_req0_rreq | i_req1_rreq;
  assign winner    = (i_req0_rreq & i_req1_rreq) ? ~rrPtr_q : i_req1_rreq;
  assign memRreq   = anyReq & (count_q != FULL_CNT);
  assign push      = memRreq & i_mem_rrdy;
  assign fifoEmpty = (count_q == '0);
  assign pop       = i_mem_dout_vld & ~fifoEmpty;
  assign headTag   = tagMem_q[rdPtr_q];

  assign o_mem_rreq  = memRreq;
  assign o_mem_addr  = !anyReq ? '0 : (winner ? i_req1_addr : i_req0_addr);
  assign o_req0_rrdy = push & ~winner;
  assign o_req1_rrdy = push & winner;

  always_comb begin
    rrPtr_d = push ? winner : rrPtr_q;
    wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    err_d = err_q | (i_mem_dout_vld & fifoEmpty);
  end

  // Returned rows are registered once and steered by the tag at the FIFO head.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rrPtr_q    <= 1'b1;
      tagMem_q   <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      req0Vld_q  <= 1'b0;
      req1Vld_q  <= 1'b0;
      req0Dout_q <= '0;
      req1Dout_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (push) begin
        tagMem_q[wrPtr_q] <= winner;
      end
      req0Vld_q <= pop & ~headTag;
      req1Vld_q <= pop & headTag;
      if (pop && !headTag) begin
        req0Dout_q <= i_mem_dout;
      end
      if (pop && headTag) begin
        req1Dout_q <= i_mem_dout;
      end
    end
  end

  assign o_req0_dout_vld = req0Vld_q;
  assign o_req1_dout_vld = req1Vld_q;
  assign o_req0_dout     = req0Dout_q;
  assign o_req1_dout     = req1Dout_q;
  assign o_err           = err_q;

endmodule
